// File: rtl/oisc_pkg.sv
// Shared definitions for the OISC move datapath: bus widths, the move
// instruction layout and the port address map decoded by every responder.
package oisc_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  // Move instruction as it leaves the ROM: {imm, dst[6:0], src_or_imm[7:0]}.
  typedef struct packed {
    logic       imm;
    logic [6:0] dst;
    logic [7:0] src;
  } instr_t;

  typedef enum logic [ADDR_W-1:0] {
    P_NULL     = 7'h00,
    P_ACC      = 7'h01,
    P_ADD      = 7'h02,
    P_SUB      = 7'h03,
    P_AND      = 7'h04,
    P_BRZ      = 7'h05,
    P_PC       = 7'h06,
    P_MEM_ADDR = 7'h08,
    P_MEM_DATA = 7'h09
  } port_e;

endpackage

// File: rtl/oisc_hazard_unit.sv
// Stall decision for the move issuer: read-after-write interlock against the
// write in flight, plus the responder wait-state handshake.
module oisc_hazard_unit
  import oisc_pkg::*;
#(
  parameter int ADDR_W = oisc_pkg::ADDR_W
) (
  input  logic              d_valid,
  input  logic              d_imm,
  input  logic [ADDR_W-1:0] d_src,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              src_wait,
  output logic              hold,
  output logic              advance
);

  logic reading;
  logic interlock;
  logic read_wait;

  assign reading = d_valid & ~d_imm;

  // No forwarding path: responders derive their read value from the written
  // one, so the read must wait until the pending write has landed.
  assign interlock = reading & wr_en & (d_src == wr_addr);
  assign read_wait = reading & src_wait;

  assign hold    = interlock | read_wait;
  assign advance = ~hold;

endmodule

// File: rtl/oisc_move_issuer.sv
// Bus initiator for the OISC datapath: decodes each move into a source read
// (D stage) and a registered destination write (W stage).
module oisc_move_issuer
  import oisc_pkg::*;
#(
  parameter int                DATA_W    = oisc_pkg::DATA_W,
  parameter int                ADDR_W    = oisc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] NULL_ADDR = oisc_pkg::NULL_ADDR,
  parameter int                CNT_W     = oisc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              flush,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_wait,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              hold,
  output logic [CNT_W-1:0]  retired
);

  instr_t            d_instr;
  logic              d_valid;
  logic              advance;
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] d_dst;

  assign src_addr = d_instr.src[ADDR_W-1:0];
  assign src_rd   = d_valid & ~d_instr.imm;
  assign d_dst    = ADDR_W'(d_instr.dst);
  assign operand  = d_instr.imm ? DATA_W'(d_instr.src) : src_data;

  oisc_hazard_unit #(
    .ADDR_W(ADDR_W)
  ) u_hazard (
    .d_valid (d_valid),
    .d_imm   (d_instr.imm),
    .d_src   (src_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .src_wait(src_wait),
    .hold    (hold),
    .advance (advance)
  );

  // D stage. A stall outranks flush: the squashed fetch is re-presented by
  // the pc block once hold drops.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_instr <= '0;
    end else if (advance) begin
      d_valid <= ~flush;
      d_instr <= instr_t'(instr);
    end
  end

  // W stage. Bubbles and stalls only drop the strobe; address and data keep
  // their last committed values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      retired <= '0;
    end else if (advance && d_valid) begin
      wr_addr <= d_dst;
      wr_data <= operand;
      wr_en   <= (d_dst != NULL_ADDR);
      retired <= retired + 1'b1;
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oisc_move_issuer.sv
// Directed bench for oisc_move_issuer: a register-file responder model plus a
// program-order scoreboard of expected writes.
module tb_oisc_move_issuer;
  import oisc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       instr;
  logic              flush;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rd;
  logic [DATA_W-1:0] src_data;
  logic              src_wait;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              hold;
  logic [CNT_W-1:0]  retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mem[2**ADDR_W];
  logic [DATA_W-1:0] shadow[2**ADDR_W];

  oisc_move_issuer dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .flush   (flush),
    .src_addr(src_addr),
    .src_rd  (src_rd),
    .src_data(src_data),
    .src_wait(src_wait),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .hold    (hold),
    .retired (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return (a == 32'h21) ? 8'h77 : DATA_W'(a * 5 + 3);
  endfunction

  // Responders: plain storage, combinational read, write on the strobed edge.
  assign src_data = mem[src_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= init_val(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Program-order model: each accepted move sees all earlier moves' results.
  task automatic accept(input logic [15:0] w);
    instr_t            f;
    logic [DATA_W-1:0] d;
    f = instr_t'(w);
    d = f.imm ? f.src : shadow[f.src[ADDR_W-1:0]];
    if (f.dst != NULL_ADDR) begin
      sb.push_back(exp_t'{f.dst, d});
      shadow[f.dst] = d;
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_wr_addr", wr_addr, e.addr);
        check("sb_wr_data", wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) shadow[i] = init_val(i);
    rst = 1'b1; flush = 1'b1; instr = '0; src_wait = 1'b0;
    tick(); tick();
    check("rst_src_addr", src_addr, 0);
    check("rst_src_rd",   src_rd,   0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_data",  wr_data,  0);
    check("rst_wr_en",    wr_en,    0);
    check("rst_hold",     hold,     0);
    check("rst_retired",  retired,  0);

    // Immediate move: 0x5C -> port 0x0A
    rst = 1'b0; flush = 1'b0; instr = 16'h8A5C; accept(instr); settle();
    check("imm_hold_t0", hold, 0);
    tick(); flush = 1'b1; instr = '0; settle();
    check("imm_src_rd_t1", src_rd, 0);
    check("imm_wr_en_t1",  wr_en,  0);
    tick(); settle();
    check("imm_wr_en_t2",   wr_en,   1);
    check("imm_wr_addr_t2", wr_addr, 7'h0A);
    check("imm_wr_data_t2", wr_data, 8'h5C);
    check("imm_src_rd_t2",  src_rd,  0);
    check("imm_retired",    retired, 1);

    // Register move: port 0x21 -> port 0x0B
    flush = 1'b0; instr = 16'h0B21; accept(instr); settle();
    tick(); flush = 1'b1; instr = '0; settle();
    check("reg_src_rd_t1",   src_rd,   1);
    check("reg_src_addr_t1", src_addr, 7'h21);
    check("reg_hold_t1",     hold,     0);
    tick(); settle();
    check("reg_wr_en_t2",   wr_en,   1);
    check("reg_wr_addr_t2", wr_addr, 7'h0B);
    check("reg_wr_data_t2", wr_data, 8'h77);
    check("reg_retired",    retired, 2);

    // RAW: write 0x05 to 0x0A, then read 0x0A into 0x0C
    flush = 1'b0; instr = 16'h8A05; accept(instr); settle();
    tick(); instr = 16'h0C0A; accept(instr); settle();
    check("raw_hold_pre", hold, 0);
    tick(); settle();
    check("raw_hold_stall",     hold,     1);
    check("raw_src_addr_stall", src_addr, 7'h0A);
    check("raw_first_write",    wr_en,    1);
    tick(); flush = 1'b1; instr = '0; settle();
    check("raw_hold_released",  hold,     0);
    check("raw_src_addr_held",  src_addr, 7'h0A);
    check("raw_bubble_wr_en",   wr_en,    0);
    tick(); settle();
    check("raw_wr_en",   wr_en,   1);
    check("raw_wr_addr", wr_addr, 7'h0C);
    check("raw_wr_data", wr_data, 8'h05);
    check("raw_retired", retired, 4);

    // Wait state: three cycles of src_wait on a read of 0x21, flush ignored
    flush = 1'b0; instr = 16'h0B21; accept(instr); settle();
    tick(); src_wait = 1'b1; flush = 1'b1; instr = '0; settle();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        tick(); settle();
      end
      check("wait_hold",     hold,     1);
      check("wait_wr_en",    wr_en,    0);
      check("wait_src_addr", src_addr, 7'h21);
    end
    tick(); src_wait = 1'b0; settle();
    check("wait_hold_done", hold,   0);
    check("wait_src_rd",    src_rd, 1);
    tick(); settle();
    check("wait_wr_en_commit", wr_en,   1);
    check("wait_wr_data",      wr_data, 8'h77);
    check("wait_retired",      retired, 5);
    tick(); settle();
    check("wait_single_write", wr_en,   0);
    check("wait_retired_hold", retired, 5);

    // Flushed fetch: nothing read, nothing written, not retired
    flush = 1'b1; instr = 16'h0B21; settle();
    tick(); instr = '0; settle();
    check("flush_src_rd", src_rd, 0);
    check("flush_hold",   hold,   0);
    tick(); settle();
    check("flush_wr_en",   wr_en,   0);
    check("flush_retired", retired, 5);

    // NULL destination: retires without a strobe
    flush = 1'b0; instr = 16'h80FF; accept(instr); settle();
    tick(); flush = 1'b1; instr = '0; settle();
    tick(); settle();
    check("null_wr_en",   wr_en,   0);
    check("null_retired", retired, 6);

    // Reset while a read is waiting
    flush = 1'b0; instr = 16'h0B21; settle();
    tick(); src_wait = 1'b1; flush = 1'b1; instr = '0; settle();
    check("midrst_hold_pre", hold, 1);
    rst = 1'b1;
    tick(); settle();
    check("midrst_src_addr", src_addr, 0);
    check("midrst_src_rd",   src_rd,   0);
    check("midrst_wr_addr",  wr_addr,  0);
    check("midrst_wr_data",  wr_data,  0);
    check("midrst_wr_en",    wr_en,    0);
    check("midrst_hold",     hold,     0);
    check("midrst_retired",  retired,  0);
    rst = 1'b0; src_wait = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      check("midrst_no_write", wr_en, 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oisc_move_issuer.md
Name: oisc_move_issuer

Overview:
- Bus initiator for the OISC datapath. Decodes each 16-bit move instruction from the program ROM into a source read and a destination write on the port bus.
- Every port block (pc, alu, memory) is a responder to this block.
- Two-stage pipeline: D (decode/read source), W (write destination).
- Includes a read-after-write interlock, a responder wait-state handshake and branch flush.

Parameters:
- DATA_W, 8, bus data width.
- ADDR_W, 7, port address width.
- NULL_ADDR, 0, destination address that discards data (no write strobe).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  16  ROM output; format {imm, dst[6:0], src_or_imm[7:0]}.
- flush  in  1  from pc block: next fetched instruction is on a wrong path; squash it.
- src_addr  out  ADDR_W  port address being read.
- src_rd  out  1  read strobe, qualifies src_addr.
- src_data  in  DATA_W  responder read data, combinational from src_addr.
- src_wait  in  1  responder not ready; data invalid this cycle.
- wr_addr  out  ADDR_W  destination port address.
- wr_data  out  DATA_W  destination write data.
- wr_en  out  1  one-cycle write strobe.
- hold  out  1  freeze pc and ROM address (stall).
- retired  out  CNT_W  count of committed non-NOP moves.

Behaviour:
- Reset:
  - D and W are invalid.
  - src_addr=0, src_rd=0, wr_addr=0, wr_data=0, wr_en=0, hold=0, retired=0.
  - The first instr after rst deasserts is accepted.
- D stage:
  - When hold=0, latches instr with d_valid=1; if flush=1 in that cycle, latches d_valid=0 instead.
  - src_addr = d_src[ADDR_W-1:0].
  - src_rd = d_valid & ~d_imm.
- Operand:
  - d_imm=1: operand = d_src (8-bit immediate); no read strobe; src_wait ignored.
  - Otherwise operand = src_data.
- W stage:
  - Registered outputs. On an advancing edge with d_valid: wr_addr<=d_dst, wr_data<=operand, wr_en<=(d_dst!=NULL_ADDR).
  - On a stall or bubble: wr_en<=0; wr_addr and wr_data hold their previous values.
- Latency: instr presented in cycle t appears as src_addr in t+1 and as wr_en in t+2, when there is no stall.
- RAW interlock:
  - Trigger: d_valid & ~d_imm & wr_en & (d_src==wr_addr).
  - Effect: one bubble. D holds, hold=1, W gets wr_en=0.
  - No forwarding: responders compute results from the written value, so the source is re-read after the write commits.
- Wait state: src_wait=1 with src_rd=1 gives hold=1 and D holds. W gets wr_en=0 for every wait cycle; src_addr is held stable.
- hold = interlock | (src_rd & src_wait). It is combinational; the pc block must not advance while hold=1.
- Flush and hold together: hold wins. D keeps its instruction; flush is ignored that cycle, and the pc block re-asserts it on the redirect cycle.
- retired:
  - Increments on each W commit with d_valid, including NULL_ADDR moves and excluding bubbles.
  - Wraps modulo 2^CNT_W.
- Reset mid-stall: clears all state next edge; no write is emitted.

Decomposition:
- Shared oisc package holds:
  - instruction field typedef (imm, dst, src) with bit positions;
  - DATA_W/ADDR_W constants;
  - NULL_ADDR;
  - the existing port address enum (ACC, ADD, BRZ, ...), so the bench can decode wr_addr.
- One natural sub-module: oisc_hazard_unit, combinational. Inputs: d_valid, d_imm, d_src, wr_en, wr_addr, src_wait. Outputs: hold and advance.

Test Plan:
- Immediate move: after reset, instr=16'h8A5C (imm, dst=0x0A, imm=0x5C). At t+2: wr_en=1, wr_addr=0x0A, wr_data=0x5C; src_rd=0 throughout; retired=1.
- Register move: instr=16'h0B21 with src_data=0x77 when src_addr=0x21. At t+1: src_rd=1, src_addr=0x21. At t+2: wr_addr=0x0B, wr_data=0x77.
- RAW bubble:
  - Sequence: 16'h8A05, then 16'h0C0A.
  - The second instruction stalls exactly one cycle; hold=1 for one cycle; src_addr=0x0A stays stable for two cycles.
  - Its write lands at 0x0C with the post-write src_data value.
- Wait state: src_wait=1 for 3 cycles on a read of 0x21. Expect hold=1 for 3 cycles, wr_en=0 for those cycles, then a single write; retired increments once.
- Flush and NULL dst:
  - flush=1 with instr=16'h0B21: no src_rd and no write; retired unchanged.
  - instr=16'h80FF (dst=NULL_ADDR): wr_en stays 0, but retired increments.
- Reset mid-wait: assert rst during src_wait. Next cycle: all outputs 0, retired=0, no wr_en pulse afterwards.
